// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the 8-bit CPU control path. The instruction
//   decoder and the assembler test vectors use the same definitions.
//   Contents:
//     OP_*        4-bit opcode values (instruction register [7:4])
//     CW_*        bit positions of the 16 control lines in a control word
//     STEP_*      micro-step numbers for fetch and execute
//     seq_state_t run/halt state of the sequencer
//     cw_bit()    one-hot control word for a single line
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Control word layout, MSB first: hlt mi ri ro io ii ai ao eo su bi oi ce co j fi
    localparam int CW_WIDTH = 16;
    localparam int CW_HLT   = 15;
    localparam int CW_MI    = 14;
    localparam int CW_RI    = 13;
    localparam int CW_RO    = 12;
    localparam int CW_IO    = 11;
    localparam int CW_II    = 10;
    localparam int CW_AI    = 9;
    localparam int CW_AO    = 8;
    localparam int CW_EO    = 7;
    localparam int CW_SU    = 6;
    localparam int CW_BI    = 5;
    localparam int CW_OI    = 4;
    localparam int CW_CE    = 3;
    localparam int CW_CO    = 2;
    localparam int CW_J     = 1;
    localparam int CW_FI    = 0;

    localparam int STEP_FETCH0 = 0;
    localparam int STEP_FETCH1 = 1;
    localparam int STEP_EXEC0  = 2;
    localparam int STEP_EXEC1  = 3;
    localparam int STEP_EXEC2  = 4;

    typedef logic [CW_WIDTH-1:0] cw_t;

    typedef enum logic {
        SEQ_RUN  = 1'b0,
        SEQ_HALT = 1'b1
    } seq_state_t;

    function automatic cw_t cw_bit(input int idx);
        return cw_t'(1) << idx;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// ---------------------------------------------------------------------------
// control_sequencer_if
//   Signals between the control sequencer and the rest of the CPU.
//   Inputs to the sequencer:  opcode[3:0], cf, zf
//   Outputs of the sequencer: step, halted, and the 16 control lines
//   modport master : the sequencer side
//   modport slave  : the CPU datapath side
//
//   Timing contract (there is no valid/ready; every cycle carries a word):
//   the control lines are a combinational function of the current step,
//   opcode, cf, zf and halted, and they are valid for the whole cycle in
//   which step shows that value. The datapath acts on them at the next
//   rising clk edge, which is also the edge at which step advances.
// ---------------------------------------------------------------------------
interface control_sequencer_if #(
    parameter int STEP_W = 3
);
    logic [3:0]        opcode;
    logic              cf;
    logic              zf;
    logic [STEP_W-1:0] step;
    logic              halted;
    logic hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi;

    modport master (
        input  opcode, cf, zf,
        output step, halted,
        output hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi
    );

    modport slave (
        output opcode, cf, zf,
        input  step, halted,
        input  hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi
    );
endinterface

// File: rtl/control_sequencer_microcode_rom.sv
// ---------------------------------------------------------------------------
// microcode_rom
//   Purely combinational microcode table.
//   Ports:
//     opcode [3:0]       instruction opcode
//     step   [STEP_W-1:0] current micro-step
//     cf, zf             ALU flags; only consulted by JC/JZ at the first
//                        execute step
//     cw     [15:0]      control word (bit layout in cpu_pkg)
//   Steps beyond the last execute step yield an all-zero word.
// ---------------------------------------------------------------------------
module microcode_rom
    import cpu_pkg::*;
#(
    parameter int STEP_W = 3
) (
    input  logic [3:0]        opcode,
    input  logic [STEP_W-1:0] step,
    input  logic              cf,
    input  logic              zf,
    output cw_t               cw
);

    always_comb begin
        cw = '0;
        if (step == STEP_W'(STEP_FETCH0)) begin
            cw = cw_bit(CW_CO) | cw_bit(CW_MI);
        end else if (step == STEP_W'(STEP_FETCH1)) begin
            cw = cw_bit(CW_RO) | cw_bit(CW_II) | cw_bit(CW_CE);
        end else if (step == STEP_W'(STEP_EXEC0)) begin
            case (opcode)
                OP_LDA, OP_ADD, OP_SUB, OP_STA: cw = cw_bit(CW_IO) | cw_bit(CW_MI);
                OP_LDI: cw = cw_bit(CW_IO) | cw_bit(CW_AI);
                OP_JMP: cw = cw_bit(CW_IO) | cw_bit(CW_J);
                // A jump not taken leaves the word empty, which ends the instruction early.
                OP_JC:  cw = cf ? (cw_bit(CW_IO) | cw_bit(CW_J)) : '0;
                OP_JZ:  cw = zf ? (cw_bit(CW_IO) | cw_bit(CW_J)) : '0;
                OP_OUT: cw = cw_bit(CW_AO) | cw_bit(CW_OI);
                OP_HLT: cw = cw_bit(CW_HLT);
                default: cw = '0;
            endcase
        end else if (step == STEP_W'(STEP_EXEC1)) begin
            case (opcode)
                OP_LDA:         cw = cw_bit(CW_RO) | cw_bit(CW_AI);
                OP_ADD, OP_SUB: cw = cw_bit(CW_RO) | cw_bit(CW_BI);
                OP_STA:         cw = cw_bit(CW_AO) | cw_bit(CW_RI);
                default:        cw = '0;
            endcase
        end else if (step == STEP_W'(STEP_EXEC2)) begin
            case (opcode)
                OP_ADD:  cw = cw_bit(CW_EO) | cw_bit(CW_AI) | cw_bit(CW_FI);
                OP_SUB:  cw = cw_bit(CW_EO) | cw_bit(CW_AI) | cw_bit(CW_SU) | cw_bit(CW_FI);
                default: cw = '0;
            endcase
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
//   Microcode sequencer for the 8-bit CPU. Holds the micro-step counter and
//   the sticky halt state, terminates instructions early when an execute
//   step has nothing to do, and fans the microcode word out to the named
//   control lines.
//   Ports:
//     clk    system clock, rising edge
//     clr_n  asynchronous active-low reset (step=0, not halted)
//     bus    control_sequencer_if.master: opcode/cf/zf in; step, halted and
//            the control lines out
//   Parameters:
//     STEPS  micro-steps per instruction (counter wraps after STEPS-1)
//     STEP_W counter width; 2**STEP_W must be >= STEPS
// ---------------------------------------------------------------------------
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int STEPS  = 5,
    parameter int STEP_W = 3
) (
    input  logic                 clk,
    input  logic                 clr_n,
    control_sequencer_if.master  bus
);

    logic [STEP_W-1:0] step_q;
    seq_state_t        state_q;
    cw_t               cw_raw;
    cw_t               cw;
    logic              last_step;
    logic              early_done;

    microcode_rom #(
        .STEP_W (STEP_W)
    ) u_rom (
        .opcode (bus.opcode),
        .step   (step_q),
        .cf     (bus.cf),
        .zf     (bus.zf),
        .cw     (cw_raw)
    );

    // While halted only hlt is driven, regardless of opcode or flags.
    assign cw = (state_q == SEQ_HALT) ? cw_bit(CW_HLT) : cw_raw;

    assign last_step  = (step_q == STEP_W'(STEPS - 1));
    // Fetch words are never empty, so the zero test only matters from T2 on.
    assign early_done = (step_q >= STEP_W'(STEP_EXEC0)) && (cw_raw == '0);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            step_q  <= '0;
            state_q <= SEQ_RUN;
        end else begin
            case (state_q)
                SEQ_RUN: begin
                    if (cw_raw[CW_HLT]) begin
                        // step is left where it is so the halting step stays visible
                        state_q <= SEQ_HALT;
                    end else if (early_done || last_step) begin
                        step_q <= '0;
                    end else begin
                        step_q <= step_q + STEP_W'(1);
                    end
                end
                SEQ_HALT: begin
                    state_q <= SEQ_HALT;
                end
                default: begin
                    state_q <= SEQ_RUN;
                    step_q  <= '0;
                end
            endcase
        end
    end

    assign bus.step   = step_q;
    assign bus.halted = (state_q == SEQ_HALT);

    assign bus.hlt = cw[CW_HLT];
    assign bus.mi  = cw[CW_MI];
    assign bus.ri  = cw[CW_RI];
    assign bus.ro  = cw[CW_RO];
    assign bus.io  = cw[CW_IO];
    assign bus.ii  = cw[CW_II];
    assign bus.ai  = cw[CW_AI];
    assign bus.ao  = cw[CW_AO];
    assign bus.eo  = cw[CW_EO];
    assign bus.su  = cw[CW_SU];
    assign bus.bi  = cw[CW_BI];
    assign bus.oi  = cw[CW_OI];
    assign bus.ce  = cw[CW_CE];
    assign bus.co  = cw[CW_CO];
    assign bus.j   = cw[CW_J];
    assign bus.fi  = cw[CW_FI];

endmodule

// File: tb/tb_control_sequencer.sv
// ---------------------------------------------------------------------------
// tb_control_sequencer
//   Self-checking bench for control_sequencer. A driver issues instructions
//   and pushes the expected per-cycle {halted, step, control word} into a
//   queue; a monitor on the falling clock edge pops and compares. The
//   expectations come from a mnemonic table of the instruction set.
// ---------------------------------------------------------------------------
module tb_control_sequencer;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    control_sequencer_if #(.STEP_W(3)) bus();

    control_sequencer #(
        .STEPS  (5),
        .STEP_W (3)
    ) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [19:0] exp_q[$];   // {halted, step[2:0], word[15:0]}

    // Line names in the order they are packed into a 16-bit word, MSB first.
    string line_names[16] = '{"hlt", "mi", "ri", "ro", "io", "ii", "ai", "ao",
                              "eo", "su", "bi", "oi", "ce", "co", "j", "fi"};
    string exec_tbl[16][3];

    task automatic init_tables();
        for (int op = 0; op < 16; op++)
            for (int k = 0; k < 3; k++)
                exec_tbl[op][k] = "";
        exec_tbl[1]  = '{"io mi", "ro ai", ""};
        exec_tbl[2]  = '{"io mi", "ro bi", "eo ai fi"};
        exec_tbl[3]  = '{"io mi", "ro bi", "eo ai su fi"};
        exec_tbl[4]  = '{"io mi", "ao ri", ""};
        exec_tbl[5]  = '{"io ai", "", ""};
        exec_tbl[6]  = '{"io j", "", ""};
        exec_tbl[7]  = '{"io j", "", ""};
        exec_tbl[8]  = '{"io j", "", ""};
        exec_tbl[14] = '{"ao oi", "", ""};
        exec_tbl[15] = '{"hlt", "", ""};
    endtask

    // Turns a space-separated list of line names into a packed word.
    function automatic logic [15:0] mask_of(string s);
        logic [15:0] m;
        int          st;
        string       tok;
        m  = '0;
        st = 0;
        for (int i = 0; i <= s.len(); i++) begin
            if (i == s.len() || s[i] == 8'h20) begin
                if (i > st) begin
                    tok = s.substr(st, i - 1);
                    for (int k = 0; k < 16; k++)
                        if (line_names[k] == tok) m[15 - k] = 1'b1;
                end
                st = i + 1;
            end
        end
        return m;
    endfunction

    // Reference: expected lines for instruction op at micro-step t with flags c/z.
    function automatic logic [15:0] model_word(int op, int t, bit c, bit z);
        if (t == 0) return mask_of("co mi");
        if (t == 1) return mask_of("ro ii ce");
        if (t == 2 && op == 7 && !c) return '0;
        if (t == 2 && op == 8 && !z) return '0;
        return mask_of(exec_tbl[op][t - 2]);
    endfunction

    function automatic logic [15:0] actual_word();
        return {bus.hlt, bus.mi, bus.ri, bus.ro, bus.io, bus.ii, bus.ai, bus.ao,
                bus.eo, bus.su, bus.bi, bus.oi, bus.ce, bus.co, bus.j, bus.fi};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [19:0] e;
        int          drivers;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("step", 32'(bus.step), 32'(e[18:16]));
            check("halted", 32'(bus.halted), 32'(e[19]));
            check("ctrl_word", 32'(actual_word()), 32'(e[15:0]));
            drivers = int'(bus.co) + int'(bus.ro) + int'(bus.io) + int'(bus.ao) + int'(bus.eo);
            check("one_bus_driver", 32'(drivers <= 1), 32'd1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(bit h, int t, logic [15:0] w);
        exp_q.push_back({h, 3'(t), w});
    endtask

    // Called one time unit after a rising edge; reset is asserted mid-cycle
    // and the outputs are checked before any further clock edge.
    task automatic do_reset();
        #2;
        clr_n = 1'b0;
        #1;
        check("reset_step", 32'(bus.step), 32'd0);
        check("reset_halted", 32'(bus.halted), 32'd0);
        check("reset_word", 32'(actual_word()), 32'(mask_of("co mi")));
        cycle();
        clr_n = 1'b1;
    endtask

    task automatic halted_phase(int t_hold);
        for (int i = 0; i < 20; i++) begin
            bus.opcode = 4'($urandom_range(0, 15));
            bus.cf     = 1'($urandom_range(0, 1));
            bus.zf     = 1'($urandom_range(0, 1));
            push(1'b1, t_hold, mask_of("hlt"));
            cycle();
        end
        do_reset();
    endtask

    // Runs one instruction from step 0. Flags at T2 are c2/z2; on every
    // other step they are random. abort_at >= 0 resets at that step.
    task automatic run_instr(int op, bit c2, bit z2, int abort_at);
        logic [15:0] w;
        bit          c, z;
        bus.opcode = 4'(op);
        for (int t = 0; t < 5; t++) begin
            if (t == abort_at) begin
                do_reset();
                return;
            end
            if (t == 2) begin
                c = c2;
                z = z2;
            end else begin
                c = 1'($urandom_range(0, 1));
                z = 1'($urandom_range(0, 1));
            end
            bus.cf = c;
            bus.zf = z;
            w = model_word(op, t, c, z);
            push(1'b0, t, w);
            cycle();
            if (w[15]) begin
                halted_phase(t);
                return;
            end
            if (t >= 2 && w == '0) return;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        init_tables();
        bus.opcode = 4'h0;
        bus.cf     = 1'b0;
        bus.zf     = 1'b0;
        #3;
        check("por_step", 32'(bus.step), 32'd0);
        check("por_halted", 32'(bus.halted), 32'd0);
        check("por_word", 32'(actual_word()), 32'(mask_of("co mi")));
        cycle();
        clr_n = 1'b1;

        run_instr(2, 1'b0, 1'b0, 3);    // ADD abandoned at step 3
        run_instr(3, 1'b0, 1'b0, -1);   // SUB full length
        run_instr(7, 1'b1, 1'b0, -1);   // JC taken
        run_instr(7, 1'b0, 1'b1, -1);   // JC not taken
        run_instr(8, 1'b0, 1'b1, -1);   // JZ taken
        run_instr(8, 1'b1, 1'b0, -1);   // JZ not taken
        run_instr(15, 1'b0, 1'b0, -1);  // HLT, hold, reset

        for (int op = 0; op < 16; op++)
            for (int f = 0; f < 4; f++)
                run_instr(op, f[1], f[0], -1);

        repeat (150) begin
            int op;
            int ab;
            op = int'($urandom_range(0, 15));
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 4)) : -1;
            run_instr(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ab);
        end

        cycle();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
